// File: rtl/req_latch4.sv
// Four-channel request conditioner: synchronize, debounce, and latch raw
// button inputs into sticky encoder requests with a one-cycle press strobe.
module req_latch4 #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    input  logic clr,
    output logic i1,
    output logic i2,
    output logic i3,
    output logic i4,
    output logic press,
    output logic valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       db;
    logic [3:0]       db_nxt;
    logic [3:0]       rise;
    logic [3:0]       lat;
    logic [3:0]       lat_nxt;
    logic [CNT_W-1:0] cnt     [4];
    logic [CNT_W-1:0] cnt_nxt [4];

    assign raw = {b4, b3, b2, b1};

    // Rise is taken from the next debounced level so the latch bit and the
    // strobe land on the same edge that the debounced level flips.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            db_nxt[n]  = db[n];
            cnt_nxt[n] = '0;
            if (s2[n] != db[n]) begin
                if (cnt[n] == CNT_MAX) begin
                    db_nxt[n] = s2[n];
                end else begin
                    cnt_nxt[n] = cnt[n] + CNT_W'(1);
                end
            end
        end
        rise = db_nxt & ~db;
    end

    // A press arriving together with clr survives the clear.
    always_comb begin
        lat_nxt = lat | rise;
        if (clr) begin
            lat_nxt = rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            db    <= '0;
            lat   <= '0;
            press <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            db    <= db_nxt;
            lat   <= lat_nxt;
            press <= |rise;
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= cnt_nxt[n];
            end
        end
    end

    assign i1    = lat[0];
    assign i2    = lat[1];
    assign i3    = lat[2];
    assign i4    = lat[3];
    assign valid = |lat;

endmodule

// File: tb/tb_req_latch4.sv
// Scoreboard bench for req_latch4: expected {i4,i3,i2,i1,press,valid}
// per edge are queued with the stimulus and compared after each edge.
module tb_req_latch4;

    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = 3;

    typedef struct {
        int         at;
        string      tag;
        logic [5:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] b;
    logic       i1, i2, i3, i4, press, valid;

    exp_t sb[$];
    int   edge_n   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   e0;

    req_latch4 #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .b1   (b[0]),
        .b2   (b[1]),
        .b3   (b[2]),
        .b4   (b[3]),
        .clr  (clr),
        .i1   (i1),
        .i2   (i2),
        .i3   (i3),
        .i4   (i4),
        .press(press),
        .valid(valid)
    );

    always #5 clk = ~clk;

    initial begin
        assert (DB_CYCLES >= 1 && DB_CYCLES < (1 << CNT_W))
        else $fatal(1, "FAIL cfg DB_CYCLES=%0d out of range", DB_CYCLES);
    end

    task automatic chk(string tag, logic [5:0] obs, logic [5:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", tag, obs, want);
        end
    endtask

    task automatic push(int at, string tag, logic [5:0] v);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic push_rng(int a, int z, string tag, logic [5:0] v);
        for (int k = a; k <= z; k++) begin
            push(k, tag, v);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        edge_n++;
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            e = sb.pop_front();
            chk($sformatf("%s@%0d", e.tag, edge_n),
                {i4, i3, i2, i1, press, valid}, e.v);
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        b   = 4'b1111;

        // reset held with all buttons pressed
        push_rng(edge_n + 1, edge_n + 3, "rst", 6'b0000_00);
        repeat (3) step();

        // release with b3 held: full latency from release
        rst = 1'b0;
        b   = 4'b0100;
        e0  = edge_n + 1;
        push_rng(e0, e0 + 4, "rel_wait", 6'b0000_00);
        push(e0 + 5, "rel_b3", 6'b0100_11);
        push(e0 + 6, "rel_b3_hold", 6'b0100_01);
        repeat (7) step();

        clr = 1'b1;
        push(edge_n + 1, "clr1", 6'b0000_00);
        step();
        clr = 1'b0;
        b   = 4'b0000;
        push_rng(edge_n + 1, edge_n + 8, "b3_off", 6'b0000_00);
        repeat (8) step();

        // clean press on b3
        b  = 4'b0100;
        e0 = edge_n + 1;
        push_rng(e0, e0 + 4, "clean_wait", 6'b0000_00);
        push(e0 + 5, "clean_b3", 6'b0100_11);
        push_rng(e0 + 6, e0 + 9, "clean_hold", 6'b0100_01);
        repeat (10) step();
        clr = 1'b1;
        push(edge_n + 1, "clr2", 6'b0000_00);
        step();
        clr = 1'b0;
        b   = 4'b0000;
        push_rng(edge_n + 1, edge_n + 8, "b3_off2", 6'b0000_00);
        repeat (8) step();

        // bounce on b2: 3 high, 1 low, 2 high, low
        push_rng(edge_n + 1, edge_n + 14, "bounce", 6'b0000_00);
        b = 4'b0010;
        repeat (3) step();
        b = 4'b0000;
        step();
        b = 4'b0010;
        repeat (2) step();
        b = 4'b0000;
        repeat (8) step();

        // stable b2 after bounce, then release
        b  = 4'b0010;
        e0 = edge_n + 1;
        push_rng(e0, e0 + 4, "b2_wait", 6'b0000_00);
        push(e0 + 5, "b2_press", 6'b0010_11);
        push_rng(e0 + 6, e0 + 9, "b2_hold", 6'b0010_01);
        repeat (10) step();
        b = 4'b0000;
        push_rng(edge_n + 1, edge_n + 8, "b2_stick", 6'b0010_01);
        repeat (8) step();

        clr = 1'b1;
        push(edge_n + 1, "clr3", 6'b0000_00);
        step();
        clr = 1'b0;

        // simultaneous b2 and b4
        b  = 4'b1010;
        e0 = edge_n + 1;
        push_rng(e0, e0 + 4, "sim_wait", 6'b0000_00);
        push(e0 + 5, "sim_press", 6'b1010_11);
        push_rng(e0 + 6, e0 + 7, "sim_hold", 6'b1010_01);
        repeat (8) step();
        b = 4'b0000;
        push_rng(edge_n + 1, edge_n + 8, "sim_stick", 6'b1010_01);
        repeat (8) step();

        clr = 1'b1;
        push(edge_n + 1, "clr4", 6'b0000_00);
        step();
        clr = 1'b0;

        // latch i1, then clr colliding with a b3 rise
        b  = 4'b0001;
        e0 = edge_n + 1;
        push_rng(e0, e0 + 4, "b1_wait", 6'b0000_00);
        push(e0 + 5, "b1_press", 6'b0001_11);
        push(e0 + 6, "b1_hold", 6'b0001_01);
        repeat (7) step();
        b = 4'b0000;
        push_rng(edge_n + 1, edge_n + 8, "b1_stick", 6'b0001_01);
        repeat (8) step();

        b  = 4'b0100;
        e0 = edge_n + 1;
        push_rng(e0, e0 + 4, "col_wait", 6'b0001_01);
        push(e0 + 5, "col_edge", 6'b0100_11);
        push(e0 + 6, "col_clr", 6'b0000_00);
        repeat (5) step();
        clr = 1'b1;
        repeat (2) step();
        clr = 1'b0;
        push_rng(edge_n + 1, edge_n + 4, "col_after", 6'b0000_00);
        repeat (4) step();
        b = 4'b0000;
        push_rng(edge_n + 1, edge_n + 8, "b3_off3", 6'b0000_00);
        repeat (8) step();

        // reset mid-count on b4: rst sampled at edge 3
        b  = 4'b1000;
        e0 = edge_n + 1;
        push_rng(e0, e0 + 8, "rmid_wait", 6'b0000_00);
        push(e0 + 9, "rmid_press", 6'b1000_11);
        push_rng(e0 + 10, e0 + 12, "rmid_hold", 6'b1000_01);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (9) step();

        repeat (2) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
